// File: rtl/alu_result_fifo.sv
// Result/flag/op FIFO behind the 4-bit ALU, with sticky flag summary and saturating drop counter.
// Optional flag-consistency checker is enabled with `define ALU_FIFO_FLAG_CHECK_EN.
//
// state   | meaning
// EMPTY   | count == 0, head invalid
// PARTIAL | 0 < count < DEPTH
// FULL    | count == DEPTH, pushes refused and counted as drops
module alu_result_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [3:0]               in_flags,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [3:0]               out_flags,
  output logic [1:0]               out_op,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [3:0]               sticky_flags,
  input  logic                     clr_sticky,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     flag_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 6;

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} occ_e;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [3:0]        sticky_q, sticky_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  occ_e              state_q, state_d;
  logic              push, pop;
  logic [EW-1:0]     head;

  assign full      = (state_q == S_FULL);
  assign empty     = (state_q == S_EMPTY);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head       = empty ? '0 : mem_q[rd_ptr_q];
  assign out_result = head[EW-1:6];
  assign out_flags  = head[5:2];
  assign out_op     = head[1:0];

  assign count        = count_q;
  assign sticky_flags = sticky_q;
  assign drop_cnt     = drop_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    sticky_d = (clr_sticky ? 4'b0000 : sticky_q) | (push ? in_flags : 4'b0000);
    drop_d   = drop_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (in_valid && !in_ready && (drop_q != {DROP_W{1'b1}}))
      drop_d = drop_q + DROP_W'(1);

    case (state_q)
      S_EMPTY:   if (push) state_d = S_PARTIAL;
      S_PARTIAL: begin
        if (push && !pop && (count_q == CW'(DEPTH - 1)))
          state_d = S_FULL;
        else if (pop && !push && (count_q == CW'(1)))
          state_d = S_EMPTY;
      end
      S_FULL:    if (pop) state_d = S_PARTIAL;
      default:   state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_EMPTY;
      sticky_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is deliberately left out of reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_result, in_flags, in_op};
  end

`ifdef ALU_FIFO_FLAG_CHECK_EN
  logic flag_err_q, flag_err_d, flag_bad;

  // N must mirror the result MSB and Z must mirror result == 0.
  assign flag_bad   = (in_flags[1] != in_result[DATA_W-1]) ||
                      (in_flags[0] != (in_result == '0));
  assign flag_err_d = flag_err_q | (push && flag_bad);
  assign flag_err   = flag_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_err_q <= 1'b0;
    else        flag_err_q <= flag_err_d;
  end
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
Downstream stage of the 4-bit ALU. It captures each ALU result, its V/C/N/Z flags and the ALUControl code that produced them into a small FIFO. It exposes the entries to the display/readout logic through a valid/ready handshake. It also keeps sticky flag summaries and a count of dropped results for board-level debug.

Parameters:
DATA_W, 4, width of the result field; must match the ALU result width.
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
DROP_W, 8, width of the saturating dropped-result counter.

Ports:
clk  input  1  single system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  producer has a result to push.
in_ready  output  1  FIFO can accept a push this cycle.
in_result  input  DATA_W  ALU result.
in_flags  input  4  {V,C,N,Z} from the ALU.
in_op  input  2  ALUControl that produced the result.
out_valid  output  1  head entry is available.
out_ready  input  1  consumer takes the head entry this cycle.
out_result  output  DATA_W  head entry result.
out_flags  output  4  head entry {V,C,N,Z}.
out_op  output  2  head entry op code.
count  output  $clog2(DEPTH)+1  number of stored entries.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
sticky_flags  output  4  OR of all accepted {V,C,N,Z} since the last clear.
clr_sticky  input  1  synchronous clear of sticky_flags.
drop_cnt  output  DROP_W  pushes refused while full; saturating.
flag_err  output  1  sticky flag-consistency error; see Optional Feature.

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: wr_ptr, rd_ptr, count, sticky_flags, drop_cnt and flag_err are all 0.
  - Consequently empty=1, full=0, out_valid=0 and in_ready=1.
  - out_result, out_flags and out_op are 0 while empty.
  - Storage contents are not reset.
- Push: occurs when in_valid && in_ready. The entry is written at wr_ptr and wr_ptr advances modulo DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr advances modulo DEPTH.
- in_ready = !full. There is no pass-through when full, even if out_ready=1 in the same cycle.
- out_valid = !empty. Head fields are read combinationally from storage at rd_ptr and forced to 0 when empty.
- Latency: an entry pushed in cycle t appears at the head in cycle t+1 if the FIFO was empty.
- Simultaneous push and pop (only possible when not full and not empty): count is unchanged and both pointers advance.
- Push into an empty FIFO with out_ready=1: no pop that cycle.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Internal occupancy state machine is derived from count:
  - EMPTY -> PARTIAL on a push.
  - PARTIAL -> FULL on a push with no pop when count == DEPTH-1.
  - PARTIAL -> EMPTY on a pop with no push when count == 1.
  - FULL -> PARTIAL on a pop.
- Sticky flags:
  - next = clr_sticky ? pushed_flags : (sticky_flags | pushed_flags).
  - pushed_flags is in_flags on a push cycle, otherwise 0.
  - When clear and push coincide, the clear wins and then the new flags are set.
- drop_cnt increments on in_valid && !in_ready and holds at 2^DROP_W-1. It is cleared only by reset.
- Payload is stored unmodified. There is no arithmetic in this block beyond pointer and counter increments.

Optional Feature:
Macro ALU_FIFO_FLAG_CHECK_EN.
- Defined: on each push, compare in_flags[1] (N) with in_result[DATA_W-1], and in_flags[0] (Z) with (in_result == 0).
  - Any mismatch sets flag_err on the next edge.
  - flag_err stays set until reset. It is not cleared by clr_sticky.
- Not defined: flag_err is tied to 0 and no checking logic is present.

Test Plan:
- Reset then idle -> empty=1, in_ready=1, out_valid=0, count=0, sticky_flags=0, drop_cnt=0.
- Push result 4'h5 with flags 4'b0000 and op 2'b00, out_ready=0 -> next cycle out_valid=1, out_result=5, out_op=0, count=1.
- Push 4'h1, 4'h2, 4'h3, 4'h4 with out_ready=0, then a fifth push 4'hF -> full=1, in_ready=0, drop_cnt=1. Pop four times with out_ready=1 -> outputs 1,2,3,4 in order, then empty=1.
- Hold full with in_valid=1 for 300 cycles -> drop_cnt saturates at 255.
- Push flags 4'b1000, then 4'b0010, then pulse clr_sticky together with a push of flags 4'b0001 -> sticky_flags goes 8, then A, then 1.
- With ALU_FIFO_FLAG_CHECK_EN: push result 4'h0 with Z=0 -> flag_err=1 next cycle. Apply reset -> flag_err=0. Without the macro, the same stimulus leaves flag_err=0.
